// File: rtl/pitch_tone_gen_if.sv
// pitch_tone_gen_if -- note command handshake for pitch_tone_gen.
//   cmd_valid : command present (driven by master)
//   cmd_ready : receiver can take a command this cycle (driven by slave)
//   cmd_on    : 1 = note on, 0 = note off
//   cmd_bin   : target tone as a 64-point FFT bin index
interface pitch_tone_gen_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_on;
  logic [4:0] cmd_bin;

  modport master (
    output cmd_valid,
    output cmd_on,
    output cmd_bin,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_on,
    input  cmd_bin,
    output cmd_ready
  );
endinterface

// File: rtl/pitch_tone_gen.sv
// pitch_tone_gen -- enveloped triangle-wave tone generator.
// A clock divider produces one sample tick every CLK_DIV cycles. Note
// commands are captured into a one-entry pending register and applied on
// the next tick; an ATTACK/SUSTAIN/RELEASE envelope scales a triangle wave
// derived from a 16-bit phase accumulator.
// Ports:
//   clk          : system clock, rising edge
//   reset        : synchronous, active-high
//   cmd          : pitch_tone_gen_if.slave command handshake
//   sample       : 12-bit offset-binary audio sample (2048 = silence)
//   sample_valid : one-cycle strobe on the cycle after each tick
//   busy         : high whenever the voice is not IDLE
module pitch_tone_gen #(
  parameter int unsigned CLK_DIV  = 50000,
  parameter int unsigned ENV_STEP = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  pitch_tone_gen_if.slave         cmd,
  output logic [11:0]             sample,
  output logic                    sample_valid,
  output logic                    busy
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [7:0] STEP8 = 8'(ENV_STEP);
  localparam logic [8:0] STEP9 = 9'(ENV_STEP);
  localparam logic [11:0] MID = 12'd2048;

  typedef enum logic [1:0] {
    IDLE,
    ATTACK,
    SUSTAIN,
    RELEASE
  } state_t;

  state_t           state, state_nx;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [15:0]      phase, phase_nx;
  logic [15:0]      inc, inc_nx;
  logic [7:0]       env, env_nx;
  logic             pend_valid;
  logic             pend_on;
  logic [4:0]       pend_bin;
  logic             accept;

  logic             note_on;
  logic             note_off;
  logic [15:0]      bin_inc;
  logic [8:0]       env_sum;
  logic [7:0]       env_up;
  logic [7:0]       env_dn;

  logic [11:0]        p;
  logic [11:0]        tri_w;
  logic signed [12:0] s;
  logic signed [21:0] s_ext;
  logic signed [21:0] env_ext;
  logic signed [21:0] prod;
  logic [11:0]        sample_nx;

  assign tick          = (div_cnt == DIV_LAST);
  assign cmd.cmd_ready = ~pend_valid;
  assign accept        = cmd.cmd_valid & ~pend_valid;
  assign busy          = (state != IDLE);

  // A note-on for bin 0 has no pitch, so it behaves as a note-off.
  assign note_on  = pend_valid & pend_on & (pend_bin != 5'd0);
  assign note_off = pend_valid & ~note_on;
  assign bin_inc  = {1'b0, pend_bin, 10'b0};

  assign env_sum = {1'b0, env} + STEP9;
  assign env_up  = env_sum[8] ? 8'hFF : env_sum[7:0];
  assign env_dn  = (env > STEP8) ? (env - STEP8) : '0;

  // Next voice state, evaluated every cycle but only committed on a tick.
  always_comb begin
    state_nx = state;
    phase_nx = phase;
    inc_nx   = inc;
    env_nx   = env;
    unique case (state)
      IDLE: begin
        phase_nx = '0;
        if (note_on) begin
          inc_nx   = bin_inc;
          env_nx   = STEP8;
          state_nx = ATTACK;
        end
      end
      ATTACK: begin
        phase_nx = phase + inc;
        if (note_off) begin
          env_nx   = env_dn;
          state_nx = RELEASE;
          if (env_dn == '0) begin
            state_nx = IDLE;
            phase_nx = '0;
          end
        end else begin
          if (note_on) inc_nx = bin_inc;
          env_nx = env_up;
          if (env_up == 8'hFF) state_nx = SUSTAIN;
        end
      end
      SUSTAIN: begin
        phase_nx = phase + inc;
        if (note_off) begin
          env_nx   = env_dn;
          state_nx = RELEASE;
          if (env_dn == '0) begin
            state_nx = IDLE;
            phase_nx = '0;
          end
        end else begin
          if (note_on) inc_nx = bin_inc;
          env_nx = 8'hFF;
        end
      end
      RELEASE: begin
        phase_nx = phase + inc;
        env_nx   = env_dn;
        if (note_on) begin
          // Retrigger from RELEASE: envelope continues from where it is.
          inc_nx   = bin_inc;
          state_nx = ATTACK;
        end else if (env_dn == '0) begin
          state_nx = IDLE;
          phase_nx = '0;
        end
      end
      default: begin
        state_nx = IDLE;
        phase_nx = '0;
      end
    endcase
  end

  // Triangle from the top 12 phase bits, centred to signed, scaled by env.
  // Taking prod >>> 8 on two's complement gives floor rounding.
  always_comb begin
    p       = phase_nx[15:4];
    tri_w   = p[11] ? ~{p[10:0], 1'b0} : {p[10:0], 1'b0};
    s       = $signed({1'b0, tri_w}) - 13'sd2048;
    s_ext   = {{9{s[12]}}, s};
    env_ext = {14'b0, env_nx};
    prod    = s_ext * env_ext;
    if (state_nx == IDLE) begin
      sample_nx = MID;
    end else begin
      sample_nx = 12'((prod >>> 8) + 22'sd2048);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt      <= '0;
      state        <= IDLE;
      phase        <= '0;
      inc          <= '0;
      env          <= '0;
      pend_valid   <= 1'b0;
      pend_on      <= 1'b0;
      pend_bin     <= '0;
      sample       <= MID;
      sample_valid <= 1'b0;
    end else begin
      div_cnt      <= tick ? '0 : div_cnt + 1'b1;
      sample_valid <= tick;
      if (tick) begin
        state      <= state_nx;
        phase      <= phase_nx;
        inc        <= inc_nx;
        env        <= env_nx;
        sample     <= sample_nx;
        pend_valid <= 1'b0;
      end
      // accept implies no pending entry, so it never collides with the
      // tick-time clear above; a same-cycle accept waits for the next tick.
      if (accept) begin
        pend_valid <= 1'b1;
        pend_on    <= cmd.cmd_on;
        pend_bin   <= cmd.cmd_bin;
      end
    end
  end

endmodule

// File: tb/tb_pitch_tone_gen.sv
// tb_pitch_tone_gen -- directed bench for pitch_tone_gen with CLK_DIV=4,
// ENV_STEP=64. Inputs driven and outputs sampled on the falling edge.
module tb_pitch_tone_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] sample;
  logic        sample_valid;
  logic        busy;

  pitch_tone_gen_if cif ();

  pitch_tone_gen #(
    .CLK_DIV (4),
    .ENV_STEP(64)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd         (cif.slave),
    .sample      (sample),
    .sample_valid(sample_valid),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge at which sample_valid is high.
  task automatic wait_sample(input string tag);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 16 && !got; i++) begin
      @(negedge clk);
      if (sample_valid) got = 1'b1;
    end
    if (!got) check_eq({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic expect_sample(input string tag, input int unsigned exp_s, input bit exp_busy);
    wait_sample(tag);
    check_eq({tag, "_sample"}, 32'(sample), exp_s);
    check_eq({tag, "_busy"}, 32'(busy), 32'(exp_busy));
  endtask

  // Present a command for one cycle; it must be taken and then stall further ones.
  task automatic issue(input string tag, input logic on, input logic [4:0] bin);
    check_eq({tag, "_rdy"}, 32'(cif.cmd_ready), 32'd1);
    cif.cmd_valid = 1'b1;
    cif.cmd_on    = on;
    cif.cmd_bin   = bin;
    @(negedge clk);
    cif.cmd_valid = 1'b0;
    check_eq({tag, "_pend"}, 32'(cif.cmd_ready), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    cif.cmd_valid = 1'b0;
    cif.cmd_on    = 1'b0;
    cif.cmd_bin   = '0;
    reset         = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    check_eq("rst_sample", 32'(sample), 32'd2048);
    check_eq("rst_sv", 32'(sample_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_rdy", 32'(cif.cmd_ready), 32'd1);

    // Idle: strobe every 4th cycle, first on the 4th edge after reset
    reset = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      check_eq("idle_sv", 32'(sample_valid), 32'((i % 4) == 0));
      if ((i % 4) == 0) check_eq("idle_sample", 32'(sample), 32'd2048);
    end
    check_eq("idle_busy", 32'(busy), 32'd0);

    // Note on bin 16 from IDLE, then one SUSTAIN tick at env 255
    issue("on16", 1'b1, 5'd16);
    expect_sample("atk1", 1536, 1'b1);
    check_eq("atk1_rdy", 32'(cif.cmd_ready), 32'd1);
    expect_sample("atk2", 2048, 1'b1);
    expect_sample("atk3", 3583, 1'b1);
    expect_sample("atk4", 2047, 1'b1);
    expect_sample("sus1", 8, 1'b1);

    // Retarget to bin 8 in SUSTAIN: phase carries on, inc 8192
    issue("ret8", 1'b1, 5'd8);
    expect_sample("ret1", 2048, 1'b1);
    expect_sample("ret2", 3068, 1'b1);
    expect_sample("ret3", 4087, 1'b1);
    expect_sample("ret4", 3067, 1'b1);

    // Note off in SUSTAIN: env 191,127,63,0
    issue("off", 1'b0, 5'd0);
    expect_sample("rel1", 2047, 1'b1);
    expect_sample("rel2", 1539, 1'b1);
    expect_sample("rel3", 1544, 1'b1);
    expect_sample("rel4", 2048, 1'b0);
    expect_sample("rel5", 2048, 1'b0);

    // Back-to-back: second command held off until after the first applies
    cif.cmd_valid = 1'b1;
    cif.cmd_on    = 1'b1;
    cif.cmd_bin   = 5'd16;
    @(negedge clk);
    check_eq("b2b_stall", 32'(cif.cmd_ready), 32'd0);
    cif.cmd_bin = 5'd8;
    wait_sample("b2b1");
    check_eq("b2b1_sample", 32'(sample), 32'd1536);
    check_eq("b2b1_rdy", 32'(cif.cmd_ready), 32'd1);
    @(negedge clk);
    cif.cmd_valid = 1'b0;
    check_eq("b2b2_pend", 32'(cif.cmd_ready), 32'd0);
    expect_sample("b2b2", 2048, 1'b1);
    expect_sample("b2b3", 2816, 1'b1);
    expect_sample("b2b4", 4087, 1'b1);

    // Note on accepted during RELEASE is honoured without waiting for IDLE
    issue("roff", 1'b0, 5'd0);
    expect_sample("rrel", 2811, 1'b1);
    issue("rre_on", 1'b1, 5'd16);
    wait_sample("rre1");
    check_eq("rre1_busy", 32'(busy), 32'd1);
    check_eq("rre1_rdy", 32'(cif.cmd_ready), 32'd1);

    // Reset mid-note with a command pending
    issue("rpend", 1'b1, 5'd4);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("mrst_sv", 32'(sample_valid), 32'd0);
    end
    check_eq("mrst_sample", 32'(sample), 32'd2048);
    check_eq("mrst_busy", 32'(busy), 32'd0);
    check_eq("mrst_rdy", 32'(cif.cmd_ready), 32'd1);
    reset = 1'b0;
    expect_sample("mrst1", 2048, 1'b0);
    expect_sample("mrst2", 2048, 1'b0);

    // Note on with bin 0 acts as note off: stays IDLE
    issue("bin0", 1'b1, 5'd0);
    expect_sample("bin0_1", 2048, 1'b0);
    check_eq("bin0_rdy", 32'(cif.cmd_ready), 32'd1);
    expect_sample("bin0_2", 2048, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
